// File: rtl/vn_eject_queue.sv
// Virtual-network ejection unit: reassembles router flits into whole messages,
// queues completed messages and hands each to one of NUM_DST local consumers.

`ifndef HEADER
`define HEADER      2'b01
`endif
`ifndef PAYLOAD
`define PAYLOAD     2'b00
`endif
`ifndef TAIL
`define TAIL        2'b10
`endif
`ifndef HEADER_TAIL
`define HEADER_TAIL 2'b11
`endif

module vn_eject_queue #(
    parameter int                       FLIT_w      = 64,
    parameter int                       MAX_FLITS   = 9,
    parameter int                       NUM_DST     = 6,
    parameter int                       DST_w       = 4,
    parameter int                       DST_LSB     = 0,
    parameter logic [NUM_DST*DST_w-1:0] DST_CODES   = 24'h54_3210,
    parameter int                       QUEUE_DEPTH = 2,
    parameter bit                       TAIL_AT_END = 1'b1,
    parameter bit                       MS_FILTER   = 1'b0,
    parameter logic [DST_w-1:0]         MS_CODE     = 4'hF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid,
    input  logic [FLIT_w-1:0]           flit,
    input  logic [1:0]                  flit_type,
    output logic                        go,
    input  logic [NUM_DST-1:0]          avail,
    output logic [NUM_DST-1:0]          req,
    output logic [MAX_FLITS*FLIT_w-1:0] msg,
    output logic [2:0]                  err,
    output logic [31:0]                 msg_cnt
);

    localparam int MSG_W = MAX_FLITS * FLIT_w;
    localparam int FN_W  = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    localparam logic [FN_W-1:0]  LAST_IDX = FN_W'(MAX_FLITS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);

    localparam logic [1:0] FT_HDR      = `HEADER;
    localparam logic [1:0] FT_PAYLOAD  = `PAYLOAD;
    localparam logic [1:0] FT_TAIL     = `TAIL;
    localparam logic [1:0] FT_HDR_TAIL = `HEADER_TAIL;

    typedef enum logic {IDLE = 1'b0, ASM = 1'b1} state_e;

    state_e                           state_q, state_d;
    logic [FN_W-1:0]                  fn_q, fn_d;
    logic [MAX_FLITS-1:0][FLIT_w-1:0] asm_q, asm_d;
    logic                             ms_drop_q, ms_drop_d;
    logic [PTR_W-1:0]                 head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [2:0]                       err_q, err_d;
    logic [31:0]                      msg_cnt_q, msg_cnt_d;
    logic [MSG_W-1:0]                 queue_q [QUEUE_DEPTH];

    logic             take, live, hdr_ms;
    logic             push, pop, xfer, drop_head, nonempty;
    logic [MSG_W-1:0] push_msg, head_msg;
    logic [FN_W-1:0]  tail_idx;
    logic [2:0]       flit_err;
    logic [NUM_DST-1:0] match;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // go depends only on registered occupancy, never on avail or valid.
    assign go     = ~rst & (count_q < DEPTH_C);
    assign take   = valid & go;
    assign live   = take & ~ms_drop_q;
    assign hdr_ms = MS_FILTER && (flit[DST_LSB +: DST_w] == MS_CODE);

    // Next-state logic for the assembly FSM and the Message-System drop latch.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        state_d   = state_q;
        ms_drop_d = ms_drop_q;
        if (take && ms_drop_q) begin
            if (flit_type == FT_TAIL || flit_type == FT_HDR_TAIL) ms_drop_d = 1'b0;
        end else if (live) begin
            case (flit_type)
                FT_HDR: begin
                    state_d   = hdr_ms ? IDLE : ASM;
                    ms_drop_d = hdr_ms;
                end
                FT_HDR_TAIL, FT_TAIL: state_d = IDLE;
                default: ;
            endcase
        end
    end

    // Assembly datapath: buffer writes, completed-message push and flit errors.
    always_comb begin
        fn_d     = fn_q;
        asm_d    = asm_q;
        push     = 1'b0;
        push_msg = '0;
        tail_idx = fn_q;
        flit_err = '0;
        if (valid && !go) flit_err[2] = 1'b1;
        if (live) begin
            case (flit_type)
                FT_HDR, FT_HDR_TAIL: begin
                    if (state_q == ASM) flit_err[0] = 1'b1;
                    if (!hdr_ms) begin
                        if (flit_type == FT_HDR) begin
                            asm_d    = '0;
                            asm_d[0] = flit;
                            fn_d     = FN_W'(1);
                        end else begin
                            push     = 1'b1;
                            push_msg = MSG_W'(flit);
                        end
                    end
                end
                FT_PAYLOAD: begin
                    if (state_q == IDLE)       flit_err[0] = 1'b1;
                    else if (fn_q == LAST_IDX) flit_err[1] = 1'b1;
                    else begin
                        asm_d[fn_q] = flit;
                        fn_d        = fn_q + 1'b1;
                    end
                end
                default: begin
                    if (state_q == IDLE) flit_err[0] = 1'b1;
                    else begin
                        // A tail that is the 2nd flit always lands in word 1.
                        if (TAIL_AT_END) tail_idx = (fn_q == FN_W'(1)) ? FN_W'(1) : LAST_IDX;
                        asm_d[tail_idx] = flit;
                        push            = 1'b1;
                        push_msg        = asm_d;
                    end
                end
            endcase
        end
    end

    // Delivery: decode the head destination, drive req/msg, pop on transfer.
    always_comb begin
        head_msg = queue_q[head_q];
        for (int i = 0; i < NUM_DST; i++) begin
            match[i] = (head_msg[DST_LSB +: DST_w] == DST_CODES[i*DST_w +: DST_w]);
        end
        nonempty  = (count_q != '0);
        req       = nonempty ? match : '0;
        msg       = nonempty ? head_msg : '0;
        xfer      = |(req & avail);
        drop_head = nonempty & ~(|match);
        pop       = xfer | drop_head;
    end

    always_comb begin
        head_d  = pop  ? ptr_next(head_q) : head_q;
        tail_d  = push ? ptr_next(tail_q) : tail_q;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        err_d     = err_q | flit_err | {drop_head, 2'b00};
        msg_cnt_d = msg_cnt_q + (xfer ? 32'd1 : 32'd0);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            fn_q      <= '0;
            asm_q     <= '0;
            ms_drop_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_q     <= '0;
            msg_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            fn_q      <= fn_d;
            asm_q     <= asm_d;
            ms_drop_q <= ms_drop_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_q     <= err_d;
            msg_cnt_q <= msg_cnt_d;
        end
    end

    // NOTE: the message store has no reset; entries are only visible via msg
    // while count_q is non-zero, and reset clears count_q.
    always_ff @(posedge clk) begin
        if (push) queue_q[tail_q] <= push_msg;
    end

    assign err     = err_q;
    assign msg_cnt = msg_cnt_q;

endmodule

// File: tb/tb_vn_eject_queue.sv
// Directed bench for vn_eject_queue: a vector table for single-flit traffic
// plus hand-written sequences for multi-flit, back-pressure, MS and reset cases.

module tb_vn_eject_queue;

    localparam int FW = 64;
    localparam int NF = 9;
    localparam int ND = 6;
    localparam int MW = FW * NF;

    localparam logic [1:0] PAY = 2'b00;
    localparam logic [1:0] HDR = 2'b01;
    localparam logic [1:0] TL  = 2'b10;
    localparam logic [1:0] HTL = 2'b11;
    localparam logic [ND-1:0] ALL = 6'b111111;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [FW-1:0] flit;
    logic [1:0]    flit_type;
    logic          go;
    logic [ND-1:0] avail;
    logic [ND-1:0] req;
    logic [MW-1:0] msg;
    logic [2:0]    err;
    logic [31:0]   msg_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    vn_eject_queue #(
        .QUEUE_DEPTH(2),
        .MS_FILTER  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .flit     (flit),
        .flit_type(flit_type),
        .go       (go),
        .avail    (avail),
        .req      (req),
        .msg      (msg),
        .err      (err),
        .msg_cnt  (msg_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          v;
        logic [1:0]    ft;
        logic [FW-1:0] f;
        logic [ND-1:0] av;
        logic [ND-1:0] exp_req;
        logic          exp_go;
        logic [2:0]    exp_err;
        logic [31:0]   exp_cnt;
        logic [FW-1:0] exp_w0;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int idx, input logic [FW-1:0] w);
        m[idx*FW +: FW] = w;
        return m;
    endfunction

    // Drive one flit for one clock, return at the following falling edge.
    task automatic send(input logic [1:0] ft, input logic [FW-1:0] f);
        valid     = 1'b1;
        flit_type = ft;
        flit      = f;
        @(negedge clk);
        valid     = 1'b0;
    endtask

    task automatic idle();
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [MW-1:0] exp_msg;

    initial begin
        rst = 1'b1; valid = 1'b0; flit = '0; flit_type = PAY; avail = '0;

        //          v    ft   flit                    avail      req        go    err     cnt    word0
        vecs[0]  = '{1'b1, HTL, 64'hC0DE_0000_0000_0002, ALL,       6'b000100, 1'b1, 3'b000, 32'd0, 64'hC0DE_0000_0000_0002};
        vecs[1]  = '{1'b0, PAY, 64'h0,                   ALL,       6'b000000, 1'b1, 3'b000, 32'd1, 64'h0};
        vecs[2]  = '{1'b1, HTL, 64'h1234_5678_9ABC_DEF5, 6'b000000, 6'b100000, 1'b1, 3'b000, 32'd1, 64'h1234_5678_9ABC_DEF5};
        vecs[3]  = '{1'b0, PAY, 64'h0,                   6'b011111, 6'b100000, 1'b1, 3'b000, 32'd1, 64'h1234_5678_9ABC_DEF5};
        vecs[4]  = '{1'b0, PAY, 64'h0,                   6'b100000, 6'b000000, 1'b1, 3'b000, 32'd2, 64'h0};
        vecs[5]  = '{1'b1, HTL, 64'h5555_0000_0000_0010, 6'b000000, 6'b000001, 1'b1, 3'b000, 32'd2, 64'h5555_0000_0000_0010};
        vecs[6]  = '{1'b1, HTL, 64'h6666_0000_0000_0021, 6'b000001, 6'b000010, 1'b1, 3'b000, 32'd3, 64'h6666_0000_0000_0021};
        vecs[7]  = '{1'b0, PAY, 64'h0,                   6'b000010, 6'b000000, 1'b1, 3'b000, 32'd4, 64'h0};
        vecs[8]  = '{1'b1, HTL, 64'h8888_0000_0000_0007, ALL,       6'b000000, 1'b1, 3'b000, 32'd4, 64'h8888_0000_0000_0007};
        vecs[9]  = '{1'b0, PAY, 64'h0,                   ALL,       6'b000000, 1'b1, 3'b100, 32'd4, 64'h0};
        vecs[10] = '{1'b1, PAY, 64'h0000_0000_0000_DEAD, ALL,       6'b000000, 1'b1, 3'b101, 32'd4, 64'h0};
        vecs[11] = '{1'b1, TL,  64'h0000_0000_0000_BEEF, ALL,       6'b000000, 1'b1, 3'b101, 32'd4, 64'h0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst go", MW'(go), MW'(1'b0));
        check("rst req", MW'(req), '0);
        check("rst msg", msg, '0);
        check("rst err", MW'(err), '0);
        check("rst msg_cnt", MW'(msg_cnt), '0);
        rst = 1'b0;
        #1 check("go after rst", MW'(go), MW'(1'b1));

        // Single-flit traffic, hold/transfer, push+pop, undeliverable, protocol errors
        for (int i = 0; i < 12; i++) begin
            valid = vecs[i].v; flit_type = vecs[i].ft; flit = vecs[i].f; avail = vecs[i].av;
            @(negedge clk);
            check($sformatf("vec%0d req", i), MW'(req), MW'(vecs[i].exp_req));
            check($sformatf("vec%0d go", i), MW'(go), MW'(vecs[i].exp_go));
            check($sformatf("vec%0d err", i), MW'(err), MW'(vecs[i].exp_err));
            check($sformatf("vec%0d msg_cnt", i), MW'(msg_cnt), MW'(vecs[i].exp_cnt));
            check($sformatf("vec%0d msg", i), msg, MW'(vecs[i].exp_w0));
        end
        valid = 1'b0;

        // Multi-flit with tail placed in the last word
        do_reset();
        avail = '0;
        send(HDR, 64'hAAAA_0000_0000_0003);
        send(PAY, 64'h0000_0000_0000_00A1);
        send(PAY, 64'h0000_0000_0000_00B2);
        send(PAY, 64'h0000_0000_0000_00C3);
        send(TL,  64'hEEEE_0000_0000_00FF);
        exp_msg = '0;
        exp_msg = put(exp_msg, 0, 64'hAAAA_0000_0000_0003);
        exp_msg = put(exp_msg, 1, 64'h0000_0000_0000_00A1);
        exp_msg = put(exp_msg, 2, 64'h0000_0000_0000_00B2);
        exp_msg = put(exp_msg, 3, 64'h0000_0000_0000_00C3);
        exp_msg = put(exp_msg, 8, 64'hEEEE_0000_0000_00FF);
        check("multi msg", msg, exp_msg);
        check("multi req", MW'(req), MW'(6'b001000));
        avail = ALL;
        idle();
        check("multi msg_cnt", MW'(msg_cnt), MW'(32'd1));
        check("multi req after pop", MW'(req), '0);
        avail = '0;

        // Header + tail pair: tail goes to word 1
        send(HDR, 64'hBBBB_0000_0000_0004);
        send(TL,  64'h0000_0000_0000_7777);
        exp_msg = put(MW'(64'hBBBB_0000_0000_0004), 1, 64'h0000_0000_0000_7777);
        check("pair msg", msg, exp_msg);
        check("pair req", MW'(req), MW'(6'b010000));
        avail = ALL;
        idle();
        check("pair msg_cnt", MW'(msg_cnt), MW'(32'd2));
        avail = '0;

        // Overflow: 9 payloads, the 8th and 9th find only the tail word left
        send(HDR, 64'hCCCC_0000_0000_0001);
        for (int k = 1; k <= 9; k++) send(PAY, 64'h5000 + 64'(k));
        check("overflow err", MW'(err), MW'(3'b010));
        send(TL, 64'h0000_0000_0000_9999);
        exp_msg = MW'(64'hCCCC_0000_0000_0001);
        for (int k = 1; k <= 7; k++) exp_msg = put(exp_msg, k, 64'h5000 + 64'(k));
        exp_msg = put(exp_msg, 8, 64'h0000_0000_0000_9999);
        check("overflow msg", msg, exp_msg);
        check("overflow req", MW'(req), MW'(6'b000010));
        avail = ALL;
        idle();
        check("overflow msg_cnt", MW'(msg_cnt), MW'(32'd3));
        avail = '0;

        // Header during assembly: the partial message is discarded
        send(HDR, 64'hD100_0000_0000_0002);
        send(PAY, 64'h0000_0000_0000_0A0A);
        send(HDR, 64'hD200_0000_0000_0003);
        send(PAY, 64'h0000_0000_0000_0B0B);
        send(TL,  64'h0000_0000_0000_0C0C);
        exp_msg = put(MW'(64'hD200_0000_0000_0003), 1, 64'h0000_0000_0000_0B0B);
        exp_msg = put(exp_msg, 8, 64'h0000_0000_0000_0C0C);
        check("rehdr err", MW'(err), MW'(3'b011));
        check("rehdr req", MW'(req), MW'(6'b001000));
        check("rehdr msg", msg, exp_msg);
        avail = ALL;
        idle();
        check("rehdr msg_cnt", MW'(msg_cnt), MW'(32'd4));
        check("rehdr queue empty", MW'(req), '0);
        idle();
        check("rehdr msg_cnt stays", MW'(msg_cnt), MW'(32'd4));

        // Back-pressure with a 2-entry queue
        avail = '0;
        do_reset();
        send(HTL, 64'hE1E1_0000_0000_0000);
        check("bp go after 1", MW'(go), MW'(1'b1));
        send(HTL, 64'hE2E2_0000_0000_0001);
        check("bp go after 2", MW'(go), MW'(1'b0));
        check("bp req full", MW'(req), MW'(6'b000001));
        send(HTL, 64'hE3E3_0000_0000_0002);
        check("bp drop err", MW'(err), MW'(3'b100));
        check("bp head msg", msg, MW'(64'hE1E1_0000_0000_0000));
        avail = ALL;
        #1 check("bp go low during pop", MW'(go), MW'(1'b0));
        @(negedge clk);
        check("bp second req", MW'(req), MW'(6'b000010));
        check("bp second msg", msg, MW'(64'hE2E2_0000_0000_0001));
        check("bp go returns", MW'(go), MW'(1'b1));
        check("bp msg_cnt 1", MW'(msg_cnt), MW'(32'd1));
        idle();
        check("bp drained", MW'(req), '0);
        check("bp msg_cnt 2", MW'(msg_cnt), MW'(32'd2));

        // Message-System filtering between normal messages
        do_reset();
        avail = ALL;
        send(HTL, 64'h4E31_0000_0000_0002);
        check("ms n1 req", MW'(req), MW'(6'b000100));
        send(HDR, 64'h4D53_0000_0000_000F);
        check("ms hdr req", MW'(req), '0);
        check("ms n1 delivered", MW'(msg_cnt), MW'(32'd1));
        send(PAY, 64'h0000_0000_0000_1001);
        check("ms pay req", MW'(req), '0);
        send(PAY, 64'h0000_0000_0000_1002);
        send(TL,  64'h0000_0000_0000_1003);
        check("ms tail req", MW'(req), '0);
        check("ms tail err", MW'(err), '0);
        send(HTL, 64'h4E32_0000_0000_0004);
        check("ms n2 req", MW'(req), MW'(6'b010000));
        check("ms n2 msg", msg, MW'(64'h4E32_0000_0000_0004));
        idle();
        check("ms msg_cnt", MW'(msg_cnt), MW'(32'd2));
        check("ms err", MW'(err), '0);

        // Asynchronous reset in the middle of a message
        avail = '0;
        send(PAY, 64'h0000_0000_0000_0001);
        check("ar pre err", MW'(err), MW'(3'b001));
        send(HTL, 64'h6161_0000_0000_0005);
        check("ar pre req", MW'(req), MW'(6'b100000));
        send(HDR, 64'h6262_0000_0000_0001);
        send(PAY, 64'h0000_0000_0000_1111);
        #2 rst = 1'b1;
        #1;
        check("ar req", MW'(req), '0);
        check("ar err", MW'(err), '0);
        check("ar msg_cnt", MW'(msg_cnt), '0);
        check("ar go", MW'(go), MW'(1'b0));
        check("ar msg", msg, '0);
        @(negedge clk);
        rst = 1'b0;
        send(HDR, 64'h6363_0000_0000_0002);
        send(PAY, 64'h0000_0000_0000_2222);
        send(TL,  64'h0000_0000_0000_3333);
        exp_msg = put(MW'(64'h6363_0000_0000_0002), 1, 64'h0000_0000_0000_2222);
        exp_msg = put(exp_msg, 8, 64'h0000_0000_0000_3333);
        check("ar post msg", msg, exp_msg);
        check("ar post req", MW'(req), MW'(6'b000100));
        check("ar post err", MW'(err), '0);
        avail = ALL;
        idle();
        check("ar post msg_cnt", MW'(msg_cnt), MW'(32'd1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
